// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. It takes a program image as a
// big-endian byte stream, packs the bytes into 32-bit words and writes them
// to instruction memory. The processor is held (cpu_hold) until the whole
// image has arrived and its XOR checksum has matched.
//
// Stream: LEN_HI, LEN_LO (word count N), 4*N data bytes (MSB first),
//         CHK = XOR of every preceding byte, including the length bytes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid     byte source has a byte on in_data
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (depends on state only)
//   mem_we       one-cycle write pulse per assembled word
//   mem_addr     word address of the write
//   mem_wdata    word being written
//   cpu_hold     1 = processor must not fetch
//   done         image loaded and checksum verified
//   err_checksum checksum mismatch on the last load
//   err_overflow declared length exceeds memory capacity
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err_checksum,
    output logic                  err_overflow
);

    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                state_reg,    state_next;
    logic [15:0]           len_reg,      len_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    // One bit wider than the address so a full-capacity image can be counted.
    logic [ADDR_WIDTH:0]   word_cnt_reg, word_cnt_next;
    logic [7:0]            xor_reg,      xor_next;
    // Only the three earlier bytes of a word need storing; the fourth comes
    // straight from in_data on the completing transfer.
    logic [23:0]           word_reg,     word_next;
    logic                  mem_we_reg,   mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]           mem_wdata_reg, mem_wdata_next;
    logic                  cpu_hold_reg, cpu_hold_next;
    logic                  done_reg,     done_next;
    logic                  err_chk_reg,  err_chk_next;
    logic                  err_ovf_reg,  err_ovf_next;

    logic                  xfer;
    logic [15:0]           len_full;

    assign in_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                      (state_reg == DATA)   || (state_reg == CHECK);
    assign xfer     = in_valid && in_ready;
    assign len_full = {len_reg[15:8], in_data};

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        byte_cnt_next  = byte_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        xor_next       = xor_reg;
        word_next      = word_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        cpu_hold_next  = cpu_hold_reg;
        done_next      = done_reg;
        err_chk_next   = err_chk_reg;
        err_ovf_next   = err_ovf_reg;

        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next    = LEN_HI;
                    done_next     = 1'b0;
                    err_chk_next  = 1'b0;
                    err_ovf_next  = 1'b0;
                    xor_next      = 8'd0;
                    word_cnt_next = '0;
                    byte_cnt_next = 2'd0;
                    cpu_hold_next = 1'b1;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_next[15:8] = in_data;
                    xor_next       = xor_reg ^ in_data;
                    state_next     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_next = len_full;
                    xor_next = xor_reg ^ in_data;
                    if (32'(len_full) > CAPACITY) begin
                        state_next   = ERROR;
                        err_ovf_next = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    xor_next      = xor_reg ^ in_data;
                    word_next     = {word_reg[15:0], in_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = word_cnt_reg[ADDR_WIDTH-1:0];
                        mem_wdata_next = {word_reg, in_data};
                        word_cnt_next  = word_cnt_reg + (ADDR_WIDTH+1)'(1);
                        if (32'(word_cnt_reg) + 32'd1 == 32'(len_reg)) begin
                            state_next = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == xor_reg) begin
                        state_next    = DONE;
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b0;
                    end else begin
                        state_next   = ERROR;
                        err_chk_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            len_reg       <= 16'd0;
            byte_cnt_reg  <= 2'd0;
            word_cnt_reg  <= '0;
            xor_reg       <= 8'd0;
            word_reg      <= 24'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'd0;
            cpu_hold_reg  <= 1'b1;
            done_reg      <= 1'b0;
            err_chk_reg   <= 1'b0;
            err_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            byte_cnt_reg  <= byte_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            xor_reg       <= xor_next;
            word_reg      <= word_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            cpu_hold_reg  <= cpu_hold_next;
            done_reg      <= done_next;
            err_chk_reg   <= err_chk_next;
            err_ovf_reg   <= err_ovf_next;
        end
    end

    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign done         = done_reg;
    assign err_checksum = err_chk_reg;
    assign err_overflow = err_ovf_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader (ADDR_WIDTH = 10). Each scenario task drives
// its byte stream and checks outputs inline; a negedge monitor logs every
// memory write so the scenarios can check address/data sequences afterwards.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err_checksum;
    logic          err_overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    // Basic image: N=2, words 0x20080005 and 0x01095020.
    // Checksum: 00^02 = 02; 20^08^00^05 = 2D; 01^09^50^20 = 78;
    //           02^2D^78 = 57.
    localparam logic [7:0] GOOD_CHK = 8'h57;
    localparam logic [7:0] BAD_CHK  = 8'h5D;
    logic [7:0] img [0:9] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h01, 8'h09, 8'h50, 8'h20};

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_checksum (err_checksum),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int wait_cnt;
        wait_cnt = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: in_ready=%b required 1 (byte %02h)", in_ready, b);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Streams the basic image with a given checksum byte, optional idle gaps
    // between bytes and an optional start pulse in the middle of DATA.
    task automatic load_basic(input logic [7:0] chk, input int gap, input bit mid_start);
        logic [7:0] b;
        for (int i = 0; i < 11; i++) begin
            b = (i == 10) ? chk : img[i];
            send_byte(b);
            if (i == 4) begin
                compared++;
                if (mem_we !== 1'b0) begin
                    mismatched++;
                    $display("FAIL early_we: mem_we=%b required 0", mem_we);
                end
            end
            if (i == 5) begin
                compared++;
                if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h20080005) begin
                    mismatched++;
                    $display("FAIL write0: we=%b addr=%0h data=%08h required we=1 addr=0 data=20080005",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (i == 9) begin
                compared++;
                if (mem_we !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 32'h01095020) begin
                    mismatched++;
                    $display("FAIL write1: we=%b addr=%0h data=%08h required we=1 addr=1 data=01095020",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (gap > 0) idle(gap);
            if (mid_start && i == 7) pulse_start();
        end
    endtask

    task automatic check_basic_log(input string tag);
        compared++;
        if (wr_addr_q.size() != 2) begin
            mismatched++;
            $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr_q.size());
        end else begin
            compared++;
            if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h20080005 ||
                wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'h01095020) begin
                mismatched++;
                $display("FAIL %s_write_log: got %0h:%08h %0h:%08h required 0:20080005 1:01095020",
                         tag, wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        idle(3);
        compared++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || err_checksum !== 1'b0 || err_overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: rdy=%b we=%b addr=%0h data=%08h hold=%b done=%b ec=%b eo=%b required 0 0 0 0 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err_checksum, err_overflow);
        end
        reset = 1'b0;
        idle(2);
        compared++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_state: in_ready=%b cpu_hold=%b required 0 1", in_ready, cpu_hold);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start();
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL start_ready: in_ready=%b required 1", in_ready);
        end
        load_basic(GOOD_CHK, 0, 1'b0);
        idle(2);
        compared++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || err_checksum !== 1'b0 ||
            err_overflow !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_result: done=%b hold=%b ec=%b eo=%b rdy=%b required 1 0 0 0 0",
                     done, cpu_hold, err_checksum, err_overflow, in_ready);
        end
        check_basic_log("basic");
        $display("test_basic_load done");
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start();
        compared++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_start_clear: done=%b hold=%b required 0 1", done, cpu_hold);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(2);
        compared++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || err_checksum !== 1'b0 || wr_addr_q.size() != 0) begin
            mismatched++;
            $display("FAIL zero_result: done=%b hold=%b ec=%b writes=%0d required 1 0 0 0",
                     done, cpu_hold, err_checksum, wr_addr_q.size());
        end
        $display("test_zero_length done");
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start();
        load_basic(BAD_CHK, 0, 1'b0);
        idle(2);
        compared++;
        if (err_checksum !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bad_chk_result: ec=%b done=%b hold=%b rdy=%b required 1 0 1 0",
                     err_checksum, done, cpu_hold, in_ready);
        end
        check_basic_log("bad_chk");
        pulse_start();
        compared++;
        if (err_checksum !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bad_chk_restart: ec=%b hold=%b rdy=%b required 0 1 1",
                     err_checksum, cpu_hold, in_ready);
        end
        // Finish with an empty image so the loader returns to DONE.
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(1);
        $display("test_bad_checksum done");
    endtask

    task automatic test_overflow();
        logic [7:0]  x;
        logic [31:0] w;
        int          bad;
        clear_log();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        idle(3);
        compared++;
        if (err_overflow !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
            cpu_hold !== 1'b1 || wr_addr_q.size() != 0) begin
            mismatched++;
            $display("FAIL overflow_1025: eo=%b rdy=%b done=%b hold=%b writes=%0d required 1 0 0 1 0",
                     err_overflow, in_ready, done, cpu_hold, wr_addr_q.size());
        end

        // Exactly full capacity: 1024 words, continuous stream.
        clear_log();
        pulse_start();
        compared++;
        if (err_overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow_clear: err_overflow=%b required 0", err_overflow);
        end
        x = 8'h04 ^ 8'h00;
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            w = {8'hA5 ^ 8'(i), 8'(i >> 8), 8'h3C, 8'(i) ^ 8'h81};
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
        end
        send_byte(x);
        idle(2);
        compared++;
        if (done !== 1'b1 || err_overflow !== 1'b0 || err_checksum !== 1'b0 || cpu_hold !== 1'b0) begin
            mismatched++;
            $display("FAIL full_result: done=%b eo=%b ec=%b hold=%b required 1 0 0 0",
                     done, err_overflow, err_checksum, cpu_hold);
        end
        compared++;
        if (wr_addr_q.size() != 1024) begin
            mismatched++;
            $display("FAIL full_write_count: got %0d required 1024", wr_addr_q.size());
        end else begin
            compared++;
            if (wr_addr_q[1023] !== 10'h3FF) begin
                mismatched++;
                $display("FAIL full_last_addr: got %0h required 3ff", wr_addr_q[1023]);
            end
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                w = {8'hA5 ^ 8'(i), 8'(i >> 8), 8'h3C, 8'(i) ^ 8'h81};
                if (wr_addr_q[i] !== 10'(i) || wr_data_q[i] !== w) bad++;
            end
            compared++;
            if (bad != 0) begin
                mismatched++;
                $display("FAIL full_sequence: %0d bad entries required 0", bad);
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_gaps_ignored_start();
        clear_log();
        pulse_start();
        load_basic(GOOD_CHK, 3, 1'b1);
        idle(2);
        compared++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || err_checksum !== 1'b0 || err_overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL gaps_result: done=%b hold=%b ec=%b eo=%b required 1 0 0 0",
                     done, cpu_hold, err_checksum, err_overflow);
        end
        check_basic_log("gaps");
        $display("test_gaps_ignored_start done");
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd0 ||
            mem_wdata !== 32'd0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_state: rdy=%b hold=%b we=%b addr=%0h data=%08h done=%b required 0 1 0 0 0 0",
                     in_ready, cpu_hold, mem_we, mem_addr, mem_wdata, done);
        end
        reset = 1'b0;
        // Bytes offered while idle must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h01;
        idle(4);
        in_valid = 1'b0;
        compared++;
        if (wr_addr_q.size() != 1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_writes: writes=%0d rdy=%b required 1 0", wr_addr_q.size(), in_ready);
        end
        clear_log();
        pulse_start();
        load_basic(GOOD_CHK, 0, 1'b0);
        idle(2);
        compared++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || err_checksum !== 1'b0) begin
            mismatched++;
            $display("FAIL reload_result: done=%b hold=%b ec=%b required 1 0 0", done, cpu_hold, err_checksum);
        end
        check_basic_log("reload");
        $display("test_reset_mid_load done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_zero_length();
        test_bad_checksum();
        test_overflow();
        test_gaps_ignored_start();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
